// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and FSM state encoding.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// Execute <-> md_unit request bus plus the continuously visible HI/LO view.
interface md_if;
  import md_pkg::*;

  // Handshake: start is a one-cycle strobe qualified by md_op/in_a/in_b,
  // sampled on a rising edge. The requester must not pulse start while start
  // or busy is high; a start seen while busy is dropped without side effects.
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  md_state_e   dbg_state;

  modport master (
    output start, md_op, in_a, in_b,
    input  busy, hi, lo, dbg_state
  );

  modport slave (
    input  start, md_op, in_a, in_b,
    output busy, hi, lo, dbg_state
  );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath working on the latched operands.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_u;
  logic [31:0] div_s;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes so that 0x80000000 / -1 cannot overflow.
  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;

  // Zero divisors are replaced so the datapath never produces X; the FSM
  // discards the result in that case anyway.
  assign div_u  = (b == 32'd0) ? 32'd1 : b;
  assign div_s  = (b == 32'd0) ? 32'd1 : abs_b;
  assign uq     = a / div_u;
  assign ur     = a % div_u;
  assign sq_mag = abs_a / div_s;
  assign sr_mag = abs_a % div_s;

  always_comb begin
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_lo      = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
        res_hi      = a[31] ? (~sr_mag + 32'd1) : sr_mag;
        div_by_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        res_lo      = uq;
        res_hi      = ur;
        div_by_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and fixed latency.
// Define MD_CANCEL_EN to add the cancel input used for exception flush.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
`ifdef MD_CANCEL_EN
  input  logic cancel,
`endif
  md_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             div_by_zero;
  logic             cancel_now;

`ifdef MD_CANCEL_EN
  assign cancel_now = cancel;
`else
  assign cancel_now = 1'b0;
`endif

  md_arith u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      op_q   <= MD_NONE;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
    end else if (cancel_now) begin
      // Flush: abort any running op and drop a coincident start, MTHI/MTLO too.
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (is_mult(bus.md_op) || is_div(bus.md_op)) begin
              op_q   <= bus.md_op;
              a_q    <= bus.in_a;
              b_q    <= bus.in_b;
              cnt    <= is_mult(bus.md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              state  <= ST_RUN;
              busy_q <= 1'b1;
            end else if (bus.md_op == MD_MTHI) begin
              hi_q <= bus.in_a;
            end else if (bus.md_op == MD_MTLO) begin
              lo_q <= bus.in_a;
            end
          end
        end
        ST_RUN: begin
          if (cnt == CNT_W'(1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            if (!div_by_zero) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases from the plan plus random
// ops checked against a plain-arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic cancel;

  md_if bus ();

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef MD_CANCEL_EN
    .cancel (cancel),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int latency(input logic [2:0] op);
    return (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
  endfunction

  // Reference: 64-bit integer arithmetic, SV division truncates toward zero.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT: begin
        p = sa * sb;
        return p;
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        return p;
      end
      MD_DIV: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at);
    int          n;
    logic [63:0] r;
    exp_q.push_back(ref_result(op, a, b, m_hi, m_lo));
    bus.start = 1'b1;
    bus.md_op = op;
    bus.in_a  = a;
    bus.in_b  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_a  = $urandom;
    bus.in_b  = $urandom;
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      n++;
      if (n == 1) check("held_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
      bus.start = (n == poke_at);
      bus.md_op = MD_MTHI;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_len", 64'(n), 64'(latency(op)));
    r = exp_q.pop_front();
    {m_hi, m_lo} = r;
    check("result", {bus.hi, bus.lo}, r);
  endtask

  task automatic quick_op(input logic [2:0] op, input logic [31:0] a);
    if (op == MD_MTHI) m_hi = a;
    if (op == MD_MTLO) m_lo = a;
    bus.start = 1'b1;
    bus.md_op = op;
    bus.in_a  = a;
    bus.in_b  = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    check("quick_busy", 64'(bus.busy), 64'(0));
    check("quick_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    cancel    = 1'b0;
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.md_op = MD_MULT;
    bus.in_a  = 32'd5;
    bus.in_b  = 32'd7;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
      check("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    end
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'(0));

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_dir", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 0);
    check("multu_dir", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_dir", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MD_DIVU, 32'd7, 32'd0, 0);
    check("divu_zero", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    quick_op(MD_MTHI, 32'h1234_5678);
    quick_op(MD_MTLO, 32'h9ABC_DEF0);
    check("mt_dir", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
    run_op(MD_DIV, 32'd100, 32'd7, 4);
    check("div_poke", {bus.hi, bus.lo}, {32'd2, 32'd14});
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

    // Reset in the middle of a divide discards it.
    bus.start = 1'b1;
    bus.md_op = MD_DIV;
    bus.in_a  = 32'd1000;
    bus.in_b  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    run_op(MD_MULT, 32'd6, 32'hFFFF_FFF9, 0);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (is_mult(op) || is_div(op)) run_op(op, a, b, $urandom_range(0, 3));
      else quick_op(op, a);
    end

`ifdef MD_CANCEL_EN
    bus.start = 1'b1;
    bus.md_op = MD_MULT;
    bus.in_a  = $urandom;
    bus.in_b  = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'(0));
    check("cancel_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    @(negedge clk);
    check("cancel_idle", 64'(bus.busy), 64'(0));
    bus.start = 1'b1;
    bus.md_op = MD_MTHI;
    bus.in_a  = ~m_hi;
    cancel    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cancel    = 1'b0;
    check("cancel_mthi", {32'd0, bus.hi}, {32'd0, m_hi});
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    run_op(MD_MULTU, $urandom, $urandom, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
